// File: rtl/answer_pkg.sv
// rtl/answer_pkg.sv - shared constants and state type for the answer frame sequencer (CSUM state under ANSWER_FRAME_CSUM_EN)
package answer_pkg;

    localparam int          ANSWER_WORDS = 20;
    localparam logic [7:0]  ANSWER_HDR   = 8'hA5;
    localparam int          ANSWER_AW    = 5;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        ADDR,
        LATCH,
        SEND
`ifdef ANSWER_FRAME_CSUM_EN
        , CSUM
`endif
    } state_t;

endpackage

// File: rtl/answer_frame_tx_if.sv
// rtl/answer_frame_tx_if.sv - ROM address/data bus and outgoing byte stream of the answer frame sequencer
interface answer_frame_tx_if;
    import answer_pkg::*;

    logic [ANSWER_AW-1:0] rom_addr;
    logic [7:0]           rom_data;
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 tx_last;

    modport master (
        output rom_addr,
        input  rom_data,
        output tx_data,
        output tx_valid,
        output tx_last,
        input  tx_ready
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        input  tx_data,
        input  tx_valid,
        input  tx_last,
        output tx_ready
    );
endinterface

// File: rtl/answer_csum_acc.sv
// rtl/answer_csum_acc.sv - 8-bit modulo-256 accumulator with clear and add-enable
module answer_csum_acc (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       add,
    input  logic [7:0] din,
    output logic [7:0] sum
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum <= 8'd0;
        end else if (clr) begin
            sum <= 8'd0;
        end else if (add) begin
            sum <= sum + din;
        end
    end
endmodule

// File: rtl/answer_frame_tx.sv
// rtl/answer_frame_tx.sv - walks the answer ROM and streams header, data words and (ANSWER_FRAME_CSUM_EN) a checksum byte
module answer_frame_tx
    import answer_pkg::*;
#(
    parameter int         NWORDS = ANSWER_WORDS,
    parameter logic [7:0] HEADER = ANSWER_HDR
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req,
    answer_frame_tx_if.master   bus,
    output logic                busy,
    output logic [7:0]          frames_sent
);
    localparam logic [ANSWER_AW-1:0] LAST_K = ANSWER_AW'(NWORDS - 1);

    state_t               state, state_nxt;
    logic [ANSWER_AW-1:0] k;
    logic [7:0]           data_q;
    logic                 accept;
    logic                 valid_c, last_c, frame_done;
    logic                 start;

    assign accept = bus.tx_valid & bus.tx_ready;
    assign start  = (state == IDLE) & req;

`ifdef ANSWER_FRAME_CSUM_EN
    logic [7:0] sum;

    answer_csum_acc u_csum (
        .clk (clk),
        .rst (rst),
        .clr (start),
        .add (state == LATCH),
        .din (bus.rom_data),
        .sum (sum)
    );
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        valid_c    = 1'b0;
        last_c     = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE:  if (req) state_nxt = HDR;
            HDR: begin
                valid_c = 1'b1;
                if (accept) state_nxt = ADDR;
            end
            ADDR:  state_nxt = LATCH;
            LATCH: state_nxt = SEND;
            SEND: begin
                valid_c = 1'b1;
`ifndef ANSWER_FRAME_CSUM_EN
                last_c  = (k == LAST_K);
`endif
                if (accept) begin
                    if (k != LAST_K) begin
                        state_nxt = ADDR;
                    end else begin
`ifdef ANSWER_FRAME_CSUM_EN
                        state_nxt  = CSUM;
`else
                        state_nxt  = IDLE;
                        frame_done = 1'b1;
`endif
                    end
                end
            end
`ifdef ANSWER_FRAME_CSUM_EN
            CSUM: begin
                valid_c = 1'b1;
                last_c  = 1'b1;
                if (accept) begin
                    state_nxt  = IDLE;
                    frame_done = 1'b1;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k           <= '0;
            data_q      <= 8'd0;
            frames_sent <= 8'd0;
        end else begin
            if (start) begin
                k <= '0;
            end else if (state == SEND && accept && k != LAST_K) begin
                k <= k + 1'b1;
            end
            if (state == LATCH) begin
                data_q <= bus.rom_data;
            end
            if (frame_done) begin
                frames_sent <= frames_sent + 8'd1;
            end
        end
    end

    // Outputs decode from the state register, so an async reset parks rom_addr at 0 at once.
    always_comb begin
        bus.tx_data = data_q;
        case (state)
            HDR:  bus.tx_data = HEADER;
`ifdef ANSWER_FRAME_CSUM_EN
            CSUM: bus.tx_data = sum;
`endif
            default: bus.tx_data = data_q;
        endcase
    end

    assign bus.rom_addr = (state == ADDR || state == LATCH || state == SEND) ? k : '0;
    assign bus.tx_valid = valid_c;
    assign bus.tx_last  = last_c;
    assign busy         = (state != IDLE);
endmodule

// File: tb/tb_answer_frame_tx.sv
// tb/tb_answer_frame_tx.sv - directed bench for answer_frame_tx with a counting answer-ROM model (ANSWER_FRAME_CSUM_EN aware)
module tb_answer_frame_tx;
    import answer_pkg::*;

`ifdef ANSWER_FRAME_CSUM_EN
    localparam int NBYTES    = 22;
    localparam int FRAME_CYC = 62;
`else
    localparam int NBYTES    = 21;
    localparam int FRAME_CYC = 61;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req = 1'b0;
    logic       busy;
    logic [7:0] frames_sent;

    answer_frame_tx_if bus ();

    answer_frame_tx dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .bus         (bus),
        .busy        (busy),
        .frames_sent (frames_sent)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Answer ROM: word k reads 10*k, word 0 reads a counter that advances each time the address returns to 0.
    logic [7:0] rom_cnt   = 8'd0;
    logic [4:0] prev_addr = 5'd0;
    always @(posedge clk) begin
        bus.rom_data <= (bus.rom_addr == 5'd0) ? rom_cnt : 8'(10 * bus.rom_addr);
        if (bus.rom_addr == 5'd0 && prev_addr != 5'd0) rom_cnt <= rom_cnt + 8'd1;
        prev_addr <= bus.rom_addr;
    end

    bit rand_ready = 1'b0;
    initial begin
        bus.tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    logic [7:0] got_q[$];
    logic       got_last[$];
    logic       stall_prev = 1'b0;
    logic [7:0] pdata;
    logic [4:0] paddr;
    logic       plast;

    always @(negedge clk) begin
        if (!rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", bus.tx_valid, 1);
                check("stall_data", bus.tx_data, pdata);
                check("stall_addr", bus.rom_addr, paddr);
                check("stall_last", bus.tx_last, plast);
            end
            if (bus.tx_valid && bus.tx_ready) begin
                got_q.push_back(bus.tx_data);
                got_last.push_back(bus.tx_last);
            end
            stall_prev = bus.tx_valid && !bus.tx_ready;
            pdata      = bus.tx_data;
            paddr      = bus.rom_addr;
            plast      = bus.tx_last;
        end
    end

    function automatic logic [7:0] exp_byte(input int i, input logic [7:0] w0);
        if (i == 0)  return 8'hA5;
        if (i == 1)  return w0;
        if (i <= 20) return 8'(10 * (i - 1));
        return w0 + 8'd108;
    endfunction

    task automatic check_frame(input string tag, input logic [7:0] w0);
        int n;
        check($sformatf("%s_len", tag), got_q.size(), NBYTES);
        n = (got_q.size() < NBYTES) ? got_q.size() : NBYTES;
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_b%0d", tag, i), got_q[i], exp_byte(i, w0));
            check($sformatf("%s_last%0d", tag, i), got_last[i], (i == NBYTES - 1) ? 1 : 0);
        end
    endtask

    // Called at a negedge; req is raised in the current cycle and the task returns at the first idle negedge.
    task automatic run_frame(input bit spam, output int cycles);
        got_q.delete();
        got_last.delete();
        req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        cycles = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (!busy) break;
            cycles++;
            req = spam && (cycles % 4 == 0);
        end
        req = 1'b0;
        check("frame_end", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int cyc;

    initial begin
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_addr", bus.rom_addr, 0);
        check("rst_data", bus.tx_data, 0);
        check("rst_valid", bus.tx_valid, 0);
        check("rst_last", bus.tx_last, 0);
        check("rst_busy", busy, 0);
        check("rst_frames", frames_sent, 0);
        rst = 1'b1;
        @(negedge clk);

        run_frame(1'b0, cyc);
        check("f1_cycles", cyc, FRAME_CYC);
        check_frame("f1", 8'd0);
        check("f1_count", frames_sent, 1);
        check("f1_idle_addr", bus.rom_addr, 0);

        run_frame(1'b0, cyc);
        check_frame("f2", 8'd1);
        check("f2_count", frames_sent, 2);

        rand_ready = 1'b1;
        run_frame(1'b0, cyc);
        rand_ready = 1'b0;
        check_frame("stall", 8'd2);
        check("stall_count", frames_sent, 3);

        run_frame(1'b1, cyc);
        check("spam_cycles", cyc, FRAME_CYC);
        check_frame("spam", 8'd3);
        check("spam_count", frames_sent, 4);

        run_frame(1'b0, cyc);
        check_frame("after_spam", 8'd4);
        check("after_spam_count", frames_sent, 5);

        got_q.delete();
        got_last.delete();
        req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (got_q.size() >= 8) break;
        end
        check("abort_reached", (got_q.size() >= 8) ? 1 : 0, 1);
        check("abort_busy_before", busy, 1);
        rst = 1'b0;
        #1;
        check("abort_addr", bus.rom_addr, 0);
        check("abort_data", bus.tx_data, 0);
        check("abort_valid", bus.tx_valid, 0);
        check("abort_last", bus.tx_last, 0);
        check("abort_busy", busy, 0);
        check("abort_frames", frames_sent, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        run_frame(1'b0, cyc);
        check("recover_cycles", cyc, FRAME_CYC);
        check_frame("recover", 8'd6);
        check("recover_count", frames_sent, 1);

        for (int f = 0; f < 255; f++) run_frame(1'b0, cyc);
        check("wrap_count", frames_sent, 0);
        run_frame(1'b0, cyc);
        check_frame("post_wrap", 8'd6);
        check("post_wrap_count", frames_sent, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
